// File: rtl/pong_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_match_ctrl
// Description : Pong match sequencer. Turns ball-miss pulses into
//               score_counter d_inc/d_clr commands and gates ball motion
//               through the serve, play, point and game-over phases.
//               Keeps binary point tallies to detect the winning score.
//
// Parameters  : WIN_SCORE   - points needed to win (1..99)
//               SERVE_TICKS - tick pulses spent in SERVE before release (>=1)
//               CNT_W       - width of the tallies and the serve timer
//
// Ports       : clk, reset        - clock, synchronous active-high reset
//               tick              - frame-rate pulse, serve timer base
//               start             - start button level (rising edge used)
//               miss_left/right   - one-cycle miss pulses from ball logic
//               pause             - pause button level (PONG_PAUSE_EN only)
//               d_inc, d_clr      - score_counter increment / clear
//               play_en           - ball motion enable
//               ball_reset        - hold ball at centre
//               serve_dir         - 0 = serve left, 1 = serve right
//               winner            - 00 none, 01 left, 10 right
//               state             - IDLE=0 SERVE=1 PLAY=2 SCORE=3 OVER=4
//                                   PAUSED=5
//
// Build macro : PONG_PAUSE_EN - adds the pause input and the PAUSED state.
//
// Revision    : 1.0 - initial release
// ============================================================================
module pong_match_ctrl #(
    parameter int WIN_SCORE   = 11,
    parameter int SERVE_TICKS = 120,
    parameter int CNT_W       = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       miss_left,
    input  logic       miss_right,
`ifdef PONG_PAUSE_EN
    input  logic       pause,
`endif
    output logic [1:0] d_inc,
    output logic       d_clr,
    output logic       play_en,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [1:0] winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_SCORE  = 3'd3,
        ST_OVER   = 3'd4,
        ST_PAUSED = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] c_win_score  = CNT_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0] c_serve_last = CNT_W'(SERVE_TICKS - 1);

    state_t           r_state,     w_state_nxt;
    logic [CNT_W-1:0] r_timer,     w_timer_nxt;
    logic [CNT_W-1:0] r_tally_l,   w_tally_l_nxt;
    logic [CNT_W-1:0] r_tally_r,   w_tally_r_nxt;
    logic [1:0]       r_d_inc,     w_d_inc_nxt;
    logic             r_d_clr,     w_d_clr_nxt;
    logic             r_play_en,   w_play_en_nxt;
    logic             r_ball_reset, w_ball_reset_nxt;
    logic             r_serve_dir, w_serve_dir_nxt;
    logic [1:0]       r_winner,    w_winner_nxt;
    logic             r_start_q;
    logic             w_start_rise;
    logic             w_pause_rise;

    assign w_start_rise = start & ~r_start_q;

`ifdef PONG_PAUSE_EN
    logic r_pause_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pause_q <= 1'b0;
        end else begin
            r_pause_q <= pause;
        end
    end

    assign w_pause_rise = pause & ~r_pause_q;
`else
    assign w_pause_rise = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = '0;
        w_tally_l_nxt   = r_tally_l;
        w_tally_r_nxt   = r_tally_r;
        w_d_inc_nxt     = 2'b00;
        w_d_clr_nxt     = 1'b0;
        w_serve_dir_nxt = r_serve_dir;
        w_winner_nxt    = r_winner;

        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) begin
                    w_state_nxt     = ST_SERVE;
                    w_d_clr_nxt     = 1'b1;
                    w_tally_l_nxt   = '0;
                    w_tally_r_nxt   = '0;
                    w_winner_nxt    = 2'b00;
                    w_serve_dir_nxt = 1'b0;
                end
            end
            ST_SERVE: begin
                // Timer only advances on tick; the tick that completes the
                // count moves straight to PLAY with the timer back at zero.
                w_timer_nxt = r_timer;
                if (tick) begin
                    if (r_timer == c_serve_last) begin
                        w_state_nxt = ST_PLAY;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (miss_left && miss_right) begin
                    // Simultaneous misses: replay the serve, nobody scores.
                    w_state_nxt = ST_SERVE;
                end else if (miss_right) begin
                    w_state_nxt     = ST_SCORE;
                    w_tally_l_nxt   = r_tally_l + 1'b1;
                    w_d_inc_nxt     = 2'b01;
                    w_serve_dir_nxt = 1'b1;
                end else if (miss_left) begin
                    w_state_nxt     = ST_SCORE;
                    w_tally_r_nxt   = r_tally_r + 1'b1;
                    w_d_inc_nxt     = 2'b10;
                    w_serve_dir_nxt = 1'b0;
                end else if (w_pause_rise) begin
                    w_state_nxt = ST_PAUSED;
                end
            end
            ST_SCORE: begin
                if (r_tally_l == c_win_score) begin
                    w_state_nxt  = ST_OVER;
                    w_winner_nxt = 2'b01;
                end else if (r_tally_r == c_win_score) begin
                    w_state_nxt  = ST_OVER;
                    w_winner_nxt = 2'b10;
                end else begin
                    w_state_nxt = ST_SERVE;
                end
            end
            ST_OVER: begin
                if (w_start_rise) begin
                    w_state_nxt   = ST_SERVE;
                    w_d_clr_nxt   = 1'b1;
                    w_tally_l_nxt = '0;
                    w_tally_r_nxt = '0;
                    w_winner_nxt  = 2'b00;
                end
            end
            ST_PAUSED: begin
                if (w_pause_rise) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Motion outputs are decoded from the next state so that, once
        // registered, they line up with the reported state. PAUSED freezes
        // the ball in place rather than recentring it.
        w_play_en_nxt    = (w_state_nxt == ST_PLAY);
        w_ball_reset_nxt = !((w_state_nxt == ST_PLAY) || (w_state_nxt == ST_PAUSED));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_tally_l    <= '0;
            r_tally_r    <= '0;
            r_d_inc      <= 2'b00;
            r_d_clr      <= 1'b0;
            r_play_en    <= 1'b0;
            r_ball_reset <= 1'b1;
            r_serve_dir  <= 1'b0;
            r_winner     <= 2'b00;
            // Primed high so a button held through reset is not a press.
            r_start_q    <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_tally_l    <= w_tally_l_nxt;
            r_tally_r    <= w_tally_r_nxt;
            r_d_inc      <= w_d_inc_nxt;
            r_d_clr      <= w_d_clr_nxt;
            r_play_en    <= w_play_en_nxt;
            r_ball_reset <= w_ball_reset_nxt;
            r_serve_dir  <= w_serve_dir_nxt;
            r_winner     <= w_winner_nxt;
            r_start_q    <= start;
        end
    end

    assign d_inc      = r_d_inc;
    assign d_clr      = r_d_clr;
    assign play_en    = r_play_en;
    assign ball_reset = r_ball_reset;
    assign serve_dir  = r_serve_dir;
    assign winner     = r_winner;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_match_ctrl
// Description : Self-checking bench for pong_match_ctrl with WIN_SCORE=3 and
//               SERVE_TICKS=3. Expected d_inc pulses are queued when a miss
//               is driven and popped when the point cycle is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_match_ctrl;

    localparam int c_win   = 3;
    localparam int c_serve = 3;

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_srv    = 3'd1;
    localparam logic [2:0] c_play   = 3'd2;
    localparam logic [2:0] c_score  = 3'd3;
    localparam logic [2:0] c_over   = 3'd4;
    localparam logic [2:0] c_paused = 3'd5;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       start;
    logic       miss_left;
    logic       miss_right;
    logic       pause;
    logic [1:0] d_inc;
    logic       d_clr;
    logic       play_en;
    logic       ball_reset;
    logic       serve_dir;
    logic [1:0] winner;
    logic [2:0] state;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0] sb_q[$];

    always #5 clk = ~clk;

    pong_match_ctrl #(
        .WIN_SCORE  (c_win),
        .SERVE_TICKS(c_serve),
        .CNT_W      (7)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .miss_left (miss_left),
        .miss_right(miss_right),
`ifdef PONG_PAUSE_EN
        .pause     (pause),
`endif
        .d_inc     (d_inc),
        .d_clr     (d_clr),
        .play_en   (play_en),
        .ball_reset(ball_reset),
        .serve_dir (serve_dir),
        .winner    (winner),
        .state     (state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives tick pulses until PLAY is reached, with a bounded budget.
    task automatic serve_to_play();
        for (int k = 0; k < 4 * c_serve && state !== c_play; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
        n_tests++;
        if (state !== c_play) begin
            n_fail++;
            $display("FAIL serve_timeout: state=%0d required=%0d", state, c_play);
        end
    endtask

    // One rally ending in the given misses; checks the point cycle against
    // the scoreboard and the following cycle against exp_after.
    task automatic score_point(input logic ml, input logic mr, input logic [2:0] exp_after);
        logic [1:0] exp_inc;
        logic [2:0] exp_st;
        logic       exp_sd;
        serve_to_play();
        exp_sd = serve_dir;
        miss_left  = ml;
        miss_right = mr;
        if (ml ^ mr) begin
            sb_q.push_back(mr ? 2'b01 : 2'b10);
            exp_sd = mr;
        end
        exp_st = (ml ^ mr) ? c_score : c_srv;
        step();
        miss_left  = 1'b0;
        miss_right = 1'b0;
        exp_inc = (sb_q.size() > 0) ? sb_q.pop_front() : 2'b00;
        n_tests++;
        if ({d_inc, state, serve_dir, d_clr} !== {exp_inc, exp_st, exp_sd, 1'b0}) begin
            n_fail++;
            $display("FAIL point_cycle: d_inc=%b state=%0d serve_dir=%b d_clr=%b required d_inc=%b state=%0d serve_dir=%b d_clr=0",
                     d_inc, state, serve_dir, d_clr, exp_inc, exp_st, exp_sd);
        end
        step();
        n_tests++;
        if ({d_inc, state} !== {2'b00, exp_after}) begin
            n_fail++;
            $display("FAIL after_point: d_inc=%b state=%0d required d_inc=00 state=%0d",
                     d_inc, state, exp_after);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; tick = 1'b0; pause = 1'b0;
        miss_left = 1'b0; miss_right = 1'b0;
        step();
        step();
        n_tests++;
        if ({state, d_inc, d_clr, play_en, ball_reset, serve_dir, winner} !==
            {c_idle, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_values: state=%0d d_inc=%b d_clr=%b play_en=%b ball_reset=%b serve_dir=%b winner=%b required 0/00/0/0/1/0/00",
                     state, d_inc, d_clr, play_en, ball_reset, serve_dir, winner);
        end
        reset = 1'b0;
        step();
        step();
        n_tests++;
        if ({state, d_clr} !== {c_idle, 1'b0}) begin
            n_fail++;
            $display("FAIL held_start: state=%0d d_clr=%b required state=0 d_clr=0", state, d_clr);
        end
    endtask

    task automatic test_start();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        n_tests++;
        if ({state, d_clr, ball_reset, play_en} !== {c_srv, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL start_press: state=%0d d_clr=%b ball_reset=%b play_en=%b required 1/1/1/0",
                     state, d_clr, ball_reset, play_en);
        end
        step();
        start = 1'b0;
        n_tests++;
        if ({state, d_clr} !== {c_srv, 1'b0}) begin
            n_fail++;
            $display("FAIL d_clr_width: state=%0d d_clr=%b required state=1 d_clr=0", state, d_clr);
        end
    endtask

    task automatic test_serve();
        for (int k = 0; k < c_serve - 1; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
        n_tests++;
        if ({state, play_en} !== {c_srv, 1'b0}) begin
            n_fail++;
            $display("FAIL serve_early: state=%0d play_en=%b required state=1 play_en=0", state, play_en);
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        n_tests++;
        if ({state, play_en, ball_reset} !== {c_play, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL serve_release: state=%0d play_en=%b ball_reset=%b required 2/1/0",
                     state, play_en, ball_reset);
        end
    endtask

    task automatic test_score();
        score_point(1'b0, 1'b1, c_srv);   // left 1 : right 0
        score_point(1'b1, 1'b0, c_srv);   // left 1 : right 1
    endtask

    task automatic test_double_miss();
        score_point(1'b1, 1'b1, c_srv);   // no point
        miss_right = 1'b1;
        step();
        miss_right = 1'b0;
        n_tests++;
        if ({d_inc, state} !== {2'b00, c_srv}) begin
            n_fail++;
            $display("FAIL miss_in_serve: d_inc=%b state=%0d required d_inc=00 state=1", d_inc, state);
        end
        // Left reaches 2 of 3; a point wrongly taken above would end the match.
        score_point(1'b0, 1'b1, c_srv);
    endtask

    task automatic test_win();
        score_point(1'b0, 1'b1, c_over);  // left 3 wins
        n_tests++;
        if ({winner, play_en, ball_reset} !== {2'b01, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL left_win: winner=%b play_en=%b ball_reset=%b required 01/0/1",
                     winner, play_en, ball_reset);
        end
        start = 1'b1;
        step();
        n_tests++;
        if ({state, d_clr, winner, d_inc} !== {c_srv, 1'b1, 2'b00, 2'b00}) begin
            n_fail++;
            $display("FAIL restart: state=%0d d_clr=%b winner=%b d_inc=%b required 1/1/00/00",
                     state, d_clr, winner, d_inc);
        end
        start = 1'b0;
        step();
        // Right had 1 point before the restart; tallies must start from zero.
        score_point(1'b1, 1'b0, c_srv);
        score_point(1'b1, 1'b0, c_srv);
        score_point(1'b1, 1'b0, c_over);
        n_tests++;
        if (winner !== 2'b10) begin
            n_fail++;
            $display("FAIL right_win: winner=%b required 10", winner);
        end
    endtask

    task automatic test_start_ignored();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        serve_to_play();
        start = 1'b1;
        step();
        start = 1'b0;
        n_tests++;
        if ({state, d_clr} !== {c_play, 1'b0}) begin
            n_fail++;
            $display("FAIL start_in_play: state=%0d d_clr=%b required state=2 d_clr=0", state, d_clr);
        end
    endtask

    task automatic test_midreset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_tests++;
        if ({state, play_en, ball_reset, d_clr} !== {c_idle, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: state=%0d play_en=%b ball_reset=%b d_clr=%b required 0/0/1/0",
                     state, play_en, ball_reset, d_clr);
        end
    endtask

`ifdef PONG_PAUSE_EN
    task automatic test_pause();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        serve_to_play();
        pause = 1'b1;
        step();
        pause = 1'b0;
        n_tests++;
        if ({state, play_en, ball_reset} !== {c_paused, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL pause_enter: state=%0d play_en=%b ball_reset=%b required 5/0/0",
                     state, play_en, ball_reset);
        end
        miss_right = 1'b1;
        step();
        miss_right = 1'b0;
        n_tests++;
        if ({state, d_inc} !== {c_paused, 2'b00}) begin
            n_fail++;
            $display("FAIL pause_miss: state=%0d d_inc=%b required state=5 d_inc=00", state, d_inc);
        end
        pause = 1'b1;
        step();
        pause = 1'b0;
        n_tests++;
        if ({state, play_en} !== {c_play, 1'b1}) begin
            n_fail++;
            $display("FAIL pause_exit: state=%0d play_en=%b required state=2 play_en=1", state, play_en);
        end
        step();
        pause = 1'b1;
        step();
        pause = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_tests++;
        if (state !== c_idle) begin
            n_fail++;
            $display("FAIL pause_reset: state=%0d required 0", state);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_start();
        test_serve();
        test_score();
        test_double_miss();
        test_win();
        test_start_ignored();
        test_midreset();
`ifdef PONG_PAUSE_EN
        test_pause();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Match sequencer for the Pong game. It drives the score_counter's d_inc/d_clr interface from ball-miss events and gates ball motion through serve, play, point and game-over phases. It sits between the ball/collision logic, which supplies the miss pulses, and the score_counter, which holds the BCD display digits. It keeps its own binary tallies to detect the win condition.

Parameters:
WIN_SCORE, 11, points needed to win; legal range 1..99, so it always fits the 2-digit BCD display.
SERVE_TICKS, 120, number of tick pulses spent in SERVE before the ball is released; must be >= 1.
CNT_W, 7, width of the internal binary tallies and the serve timer.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
tick  in  1  one-cycle frame-rate pulse (e.g. 60 Hz refresh tick); serve timer base.
start  in  1  level button input; the block detects its rising edge internally.
miss_left  in  1  one-cycle pulse: ball passed the left paddle, so the right player scores.
miss_right  in  1  one-cycle pulse: ball passed the right paddle, so the left player scores.
d_inc  out  2  to score_counter: 01 = left player +1 (dig1:dig0); 10 = right player +1 (dig3:dig2); 00 = idle.
d_clr  out  1  to score_counter: clear all digits.
play_en  out  1  ball motion enable.
ball_reset  out  1  hold the ball at centre.
serve_dir  out  1  0 = serve toward left, 1 = serve toward right.
winner  out  2  00 = none, 01 = left player, 10 = right player.
state  out  3  IDLE=0, SERVE=1, PLAY=2, SCORE=3, OVER=4, PAUSED=5.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, d_inc 00, d_clr 0, play_en 0, ball_reset 1, serve_dir 0, winner 00, tallies 0, timer 0, start edge detector primed with start=1, so a button held through reset does not start a match.
- Reset mid-match returns to IDLE at the next edge. The block does not pulse d_clr on reset; score_counter has its own reset.
- Start edge: start_rise = start & ~start_q.
- IDLE: ball_reset=1, play_en=0.
  - start_rise -> SERVE; d_clr=1 for exactly the next cycle; tallies, winner and serve_dir cleared.
- SERVE: ball_reset=1, play_en=0.
  - Timer increments on each tick.
  - When the count reaches SERVE_TICKS -> PLAY, and the timer clears. Exit happens on the edge that samples the SERVE_TICKS-th tick.
- PLAY: ball_reset=0, play_en=1.
  - miss_right alone -> SCORE; left tally +1; d_inc=01 for exactly one cycle; serve_dir=1 (serve toward the player who conceded).
  - miss_left alone -> SCORE; right tally +1; d_inc=10 for exactly one cycle; serve_dir=0.
  - Both misses in the same cycle -> SERVE; no point awarded; d_inc stays 00.
- SCORE lasts one cycle; play_en=0, ball_reset=1.
  - Updated tally == WIN_SCORE -> OVER; winner is set to 01 or 10.
  - Otherwise -> SERVE.
- OVER: play_en=0, ball_reset=1, winner held.
  - start_rise -> SERVE with a d_clr pulse; tallies and winner cleared.
- Misses outside PLAY are ignored. start_rise outside IDLE/OVER is ignored. Ticks outside SERVE are ignored.
- d_inc and d_clr are never asserted in the same cycle. No more than one d_inc pulse occurs per miss event.
- Tallies never exceed WIN_SCORE. score_counter wrap at 99 is therefore unreachable.

Optional Feature:
PONG_PAUSE_EN
- Defined: adds input port pause (level). A rising edge on pause in PLAY -> PAUSED, with play_en=0 and ball_reset=0 so the ball freezes in place. A rising edge on pause in PAUSED -> PLAY. Misses are ignored in PAUSED. Reset always exits PAUSED to IDLE.
- Undefined: no pause port, PAUSED is unreachable, and state never reports 5.

Test Plan:
1. Reset with start held high, release, press -> no start before release; after the press, d_clr high exactly 1 cycle, state=SERVE, ball_reset=1.
2. SERVE_TICKS=3: three tick pulses -> state=PLAY on the edge after the 3rd tick; play_en=1, ball_reset=0.
3. PLAY, miss_right pulse -> d_inc=01 for exactly 1 cycle, serve_dir=1, state SCORE then SERVE; miss_left -> d_inc=10 once, serve_dir=0.
4. miss_left and miss_right in the same cycle -> d_inc stays 00, state=SERVE, tallies unchanged; a miss during SERVE -> no d_inc.
5. WIN_SCORE=3: three left points -> after the third d_inc=01, state=OVER, winner=01, play_en=0; start press -> d_clr pulse, winner=00, state=SERVE.
6. With PONG_PAUSE_EN: pause rise in PLAY -> state=5, play_en=0, miss_right ignored; second rise -> PLAY; reset while PAUSED -> IDLE.
